rr_packet_arbiter: RTL
======================

Name: rr_packet_arbiter

Overview:
- Per-master-port packet arbiter for the crossbar. One instance per master port, selected by `number`.
- Selects among S_DATA_COUNT slave streams whose destination matches `number`, in round-robin order. Optional per-slave weights.
- Holds the grant for a whole packet, up to the beat carrying last.
- Forwards beats through a 2-entry output buffer, giving per-slave one-hot ready and a registered, ready-independent m_valid_o.

Parameters:
- T_DATA_WIDTH, 8, data beat width.
- S_DATA_COUNT, 4, number of slave (input) streams.
- M_DATA_COUNT, 3, number of master ports in the crossbar.
- T_ID___WIDTH, $clog2(S_DATA_COUNT), slave id width.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), destination width.
- WEIGHT_WIDTH, 4, per-slave weight width (packets per turn).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- number  in  T_DEST_WIDTH  index of the master port this arbiter serves; static.
- s_data_i  in  T_DATA_WIDTH x S_DATA_COUNT  slave data.
- s_dest_i  in  T_DEST_WIDTH x S_DATA_COUNT  slave destination.
- s_last_i  in  S_DATA_COUNT  last beat of packet.
- s_valid_i  in  S_DATA_COUNT  slave valid.
- s_weight_i  in  WEIGHT_WIDTH x S_DATA_COUNT  weights; ignored unless WEIGHTED_RR_EN is defined.
- s_ready_o  out  S_DATA_COUNT  one-hot per-slave ready.
- m_ready_i  in  1  master ready.
- m_valid_o  out  1  master valid.
- m_last_o  out  1  master last.
- m_data_o  out  T_DATA_WIDTH  master data.
- m_id_o  out  T_ID___WIDTH  id of the originating slave.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - In reset: m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0, s_ready_o=0.
  - In reset: buffer count=0, state=IDLE, pointer=S_DATA_COUNT-1 (slave 0 has first priority), credit=0.
- Candidate: slave i with s_valid_i[i] && s_dest_i[i]==number.
- State IDLE:
  - s_ready_o=0.
  - If any candidate, grant the first candidate found searching pointer+1, pointer+2, ... modulo S_DATA_COUNT.
  - Register cur=granted id, load credit (see Optional Feature), go LOCK.
  - If no candidate, stay IDLE.
- State LOCK:
  - s_ready_o[cur] = (count<2). All other bits are 0.
  - Beat accepted when s_valid_i[cur] && s_ready_o[cur]; push {data, last, cur} into the buffer.
  - s_dest_i is not rechecked mid-packet; dest is constant within a packet by protocol.
  - On acceptance of a beat with last=1, go IDLE and update pointer (see Optional Feature). This costs one bubble cycle per packet.
- Output buffer:
  - 2-entry FIFO. Head drives m_*. m_valid_o = (count!=0).
  - Pop on m_valid_o && m_ready_i. Push and pop in the same cycle leave count unchanged.
  - m_data_o, m_last_o and m_id_o hold stable while m_valid_o && !m_ready_i.
  - m_valid_o never depends combinationally on m_ready_i.
- Latency:
  - Beat accepted at edge N with an empty buffer: m_valid_o=1 after edge N.
  - First beat of a packet: earliest acceptance is the cycle after the grant edge.
- Throughput: 1 beat/cycle within a packet while m_ready_i=1.
- Backpressure: count==2 forces s_ready_o=0. Beats are never lost, duplicated or reordered.
- Boundaries:
  - Pointer wraps S_DATA_COUNT-1 → 0.
  - Non-power-of-two S_DATA_COUNT: ids ≥ S_DATA_COUNT are never searched.
  - Single-beat packet (last on first beat): LOCK lasts exactly one accepting cycle.
  - Granted slave drops valid mid-packet: stay LOCK and wait. No timeout.
  - Reset mid-packet: buffered beats are discarded, outputs go to reset values immediately, and arbitration restarts from slave 0.

Optional Feature:
- Macro: WEIGHTED_RR_EN.
- Defined:
  - On grant, credit = s_weight_i[cur], with 0 treated as 1.
  - On each last-beat acceptance, credit decrements.
  - If the remaining credit is >0, pointer = cur-1 modulo S_DATA_COUNT, so cur has first priority at the next IDLE arbitration if it is still a candidate.
  - If the remaining credit is 0, pointer = cur.
  - If cur is not a candidate at IDLE, normal search proceeds and credit is reloaded for the new grant.
- Undefined:
  - s_weight_i is ignored and credit logic is absent.
  - On last-beat acceptance, pointer = cur (plain round robin).

Test Plan:
- Slave 1 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with last) to dest=number=1, m_ready_i=1 → m_data_o 0xA1/0xA2/0xA3 on consecutive cycles, each one cycle after acceptance. m_id_o=1. m_last_o=1 only with 0xA3.
- Slaves 0 and 2 continuously send single-beat packets to number → grants alternate 0,2,0,2. One idle cycle between packets. After reset, slave 0 is served first.
- 4-beat packet with m_ready_i held low for 4 cycles from beat 2 → count reaches 2, s_ready_o[cur] falls to 0, all 4 beats delivered in order without duplication, m_* stable while stalled.
- Slave 3 valid with dest=0 while number=1 and slave 1 idle → slave 3 never granted, s_ready_o=0, m_valid_o=0.
- WEIGHTED_RR_EN defined, weights 3 and 1, slaves 0 and 1 always requesting single-beat packets → packet order 0,0,0,1,0,0,0,1. With the macro undefined → 0,1,0,1.
- rst_n asserted at beat 2 of a 5-beat packet with 2 beats buffered → m_valid_o=0 and s_ready_o=0 immediately. After release, a new request from slave 2 is granted and its data appears with no stale beats.

Source files
------------

// File: rtl/rr_packet_arbiter.sv
// Per-master-port packet arbiter: round-robin over matching slave streams, grant held per packet,
// 2-entry output buffer. Define WEIGHTED_RR_EN for per-slave packet weights.
module rr_packet_arbiter #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 4,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT),
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [T_DEST_WIDTH-1:0]                   number,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  input  logic [S_DATA_COUNT-1:0][WEIGHT_WIDTH-1:0] s_weight_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  input  logic                                      m_ready_i,
  output logic                                      m_valid_o,
  output logic                                      m_last_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_ID___WIDTH-1:0]                   m_id_o
);

  localparam logic [T_ID___WIDTH-1:0] LastId = T_ID___WIDTH'(S_DATA_COUNT - 1);

  typedef enum logic {StIdle, StLock} state_e;

  state_e                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [T_ID___WIDTH-1:0] cur_q, cur_d;

  logic [1:0][T_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]                   buf_last_q, buf_last_d;
  logic [1:0][T_ID___WIDTH-1:0] buf_id_q, buf_id_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   cnt_q, cnt_d;

  logic [S_DATA_COUNT-1:0] cand;
  logic                    grant_vld;
  logic [T_ID___WIDTH-1:0] grant_id;
  logic [T_ID___WIDTH-1:0] idx;
  logic                    push, pop, has_room;
  logic [T_ID___WIDTH-1:0] cur_prev;

  always_comb begin
    for (int i = 0; i < int'(S_DATA_COUNT); i++) begin
      cand[i] = s_valid_i[i] && (s_dest_i[i] == number);
    end
  end

  // Modulo search only ever produces ids below S_DATA_COUNT.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= S_DATA_COUNT; k++) begin
      idx = T_ID___WIDTH'((32'(ptr_q) + k) % S_DATA_COUNT);
      if (!grant_vld && cand[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign has_room  = (cnt_q != 2'd2);
  assign push      = (state_q == StLock) && s_valid_i[cur_q] && has_room;
  assign pop       = (cnt_q != 2'd0) && m_ready_i;
  assign cur_prev  = (cur_q == '0) ? LastId : cur_q - 1'b1;

  always_comb begin
    s_ready_o = '0;
    if (state_q == StLock) begin
      s_ready_o[cur_q] = has_room;
    end
  end

`ifdef WEIGHTED_RR_EN
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          cur_d   = grant_id;
          state_d = StLock;
          // Keep remaining credit when the same slave wins again on its own turn.
          if (credit_q == '0 || grant_id != cur_q) begin
            credit_d = (s_weight_i[grant_id] == '0) ? WEIGHT_WIDTH'(1) : s_weight_i[grant_id];
          end
        end
      end
      StLock: begin
        if (push && s_last_i[cur_q]) begin
          state_d  = StIdle;
          credit_d = credit_q - 1'b1;
          ptr_d    = (credit_q > WEIGHT_WIDTH'(1)) ? cur_prev : cur_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^{s_weight_i, cur_prev};

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          cur_d   = grant_id;
          state_d = StLock;
        end
      end
      StLock: begin
        if (push && s_last_i[cur_q]) begin
          state_d = StIdle;
          ptr_d   = cur_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end
`endif

  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_id_d   = buf_id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = s_data_i[cur_q];
      buf_last_d[wr_ptr_q] = s_last_i[cur_q];
      buf_id_d[wr_ptr_q]   = cur_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = buf_data_q[rd_ptr_q];
  assign m_last_o  = buf_last_q[rd_ptr_q];
  assign m_id_o    = buf_id_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= LastId;
      cur_q      <= '0;
      buf_data_q <= '0;
      buf_last_q <= '0;
      buf_id_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_id_q   <= buf_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
